fetch_stage_ctrl: RTL and testbench
===================================

// Module: fetch_stage_ctrl
// PURPOSE
//  Instruction-fetch controller and IF/ID pipeline register; consumes the stall/flush/redirect signals from hazard detection.
//  Holds the PC, drives a variable-latency instruction-memory port, and loads IF/ID.
//  Reports its own memory-wait stall back to hazard detection. Sits between instruction memory and the decode stage.
// PARAMETERS
//  PC_W        16       PC / address width; byte-addressed, 2-byte instructions
//  INSTR_W     16       instruction word width
//  RESET_PC    16'h0000 PC value after reset
//  NOP_INSTR   16'h0000 bubble word loaded into IF/ID on flush/wait (ADD $0,$0,$0)
// PORTS
//  clk            in   1       system clock, rising edge
//  rst            in   1       synchronous, active-high reset
//  PC_stall       in   1       hold PC (hazard unit)
//  IF_ID_stall    in   1       hold IF/ID contents (hazard unit)
//  IF_flush       in   1       replace IF/ID with bubble (hazard unit)
//  update_PC      in   1       taken branch resolved in ID; redirect fetch
//  branch_target  in   PC_W    redirect address, valid with update_PC
//  imem_rdata     in   INSTR_W instruction-memory read data
//  imem_ready     in   1       imem_rdata valid this cycle for the outstanding request
//  imem_addr      out  PC_W    fetch address (= PC register)
//  imem_en        out  1       fetch request
//  fetch_stall    out  1       fetch waiting on memory; stalls downstream consumers
//  PC_curr        out  PC_W    current PC
//  IF_ID_PC_next  out  PC_W    PC+2 of the instruction in IF/ID
//  IF_ID_instr    out  INSTR_W instruction in IF/ID
//  IF_ID_valid    out  1       IF/ID holds a real instruction (0 = bubble)
//  halted         out  1       HLT has reached IF/ID; fetch frozen
// BEHAVIOUR
//  Reset values: PC=RESET_PC, IF_ID_instr=NOP_INSTR, IF_ID_PC_next=0, IF_ID_valid=0, state=FETCH,
//   redirect_pend=0, halted=0, fetch_stall=0. rst overrides every other input in the same cycle.
//  States:
//   FETCH: imem_en=1, imem_addr=PC.
//    imem_ready=1:
//     - PC <= PC_stall ? PC : PC+2 (modulo 2^PC_W; 16'hFFFE wraps to 0).
//     - Unless IF_ID_stall: IF_ID <= {rdata, PC+2, valid=1}.
//    imem_ready=0: -> WAIT; PC held.
//   WAIT: imem_en=1, address held; fetch_stall=1. Unless IF_ID_stall, IF_ID <= bubble.
//    imem_ready=1: with no pending redirect, behave as FETCH-with-ready this cycle and go to FETCH.
//    With a pending redirect: discard rdata, PC <= saved target, IF_ID <= bubble, clear pending, go to FETCH.
//   HALT: imem_en=0, PC and IF_ID frozen, halted=1. Exit only via rst.
//  Redirect: update_PC overrides PC_stall.
//   - In FETCH: PC <= branch_target, whatever imem_ready.
//   - In WAIT: latch target into redirect_pend/target reg; the outstanding access completes first.
//   - A second update_PC while pending overwrites the saved target.
//  Flush: IF_flush beats IF_ID_stall; IF_ID <= {NOP_INSTR, 0, valid=0}.
//  Halt entry: IF_ID_valid=1, IF_ID_instr[15:12]==4'hF and IF_flush=0 -> HALT next cycle.
//   Younger fetches already issued are dropped.
//  Latency: instruction presented at PC in cycle N reaches IF_ID outputs at N+1 when imem_ready=1.
//  Simultaneous: PC_stall & update_PC -> redirect wins. IF_ID_stall & IF_flush -> flush wins.
// STRUCTURE
//  Shared package entry: state encoding (FETCH/WAIT/HALT), HLT opcode 4'hF, NOP_INSTR, INSTR_BYTES=2.
//  One sub-module: if_id_reg (IF/ID register with load/hold/flush priority).
//  PC register, redirect latch and FSM stay in this module.
// TESTING
//  1 Reset, imem_ready=1, no stalls: PC 0,2,4,6; IF_ID_PC_next 2,4,6; IF_ID_valid=1 from cycle 2.
//  2 PC_stall=IF_ID_stall=1 for 2 cycles at PC=8: PC stays 8, IF_ID unchanged; release -> PC=10.
//  3 update_PC with target 16'h0040 and IF_flush at PC=12:
//    next PC=0x40, IF_ID_valid=0, IF_ID_instr=NOP; following cycle fetches 0x40.
//  4 imem_ready low 3 cycles at PC=4: fetch_stall=1 for 3 cycles, imem_addr=4, bubbles in IF/ID; then rdata latched, PC=6.
//  5 update_PC(0x80) during WAIT: rdata on ready discarded, PC=0x80, fetch_stall drops, next fetch from 0x80.
//  6 HLT (0xF000) latched into IF/ID: halted=1 next cycle, imem_en=0, PC frozen 10 cycles;
//    rst clears PC to 0 and halted to 0.

Source files
------------

// File: rtl/fetch_stage_ctrl_pkg.sv
// Shared definitions for the instruction-fetch controller: FSM encoding,
// HLT opcode, bubble word and instruction size.
package fetch_stage_ctrl_pkg;

   typedef enum logic [1:0] {
      StFetch = 2'd0,
      StWait  = 2'd1,
      StHalt  = 2'd2
   } fetch_state_e;

   localparam logic [3:0]  HLT_OPCODE  = 4'hF;
   localparam logic [15:0] DEFAULT_NOP = 16'h0000;  // ADD $0,$0,$0
   localparam int unsigned INSTR_BYTES = 2;

endpackage

// File: rtl/fetch_stage_ctrl_if_id_reg.sv
// IF/ID pipeline register. Priority: reset > flush > hold > load > bubble.
module fetch_stage_ctrl_if_id_reg #(
   parameter int unsigned         PC_W      = 16,
   parameter int unsigned         INSTR_W   = 16,
   parameter logic [INSTR_W-1:0]  NOP_INSTR = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               hold,
   input  logic               load,
   input  logic [INSTR_W-1:0] instr_in,
   input  logic [PC_W-1:0]    pc_next_in,
   output logic [INSTR_W-1:0] instr,
   output logic [PC_W-1:0]    pc_next,
   output logic               valid
);

   logic [INSTR_W-1:0] instr_q;
   logic [PC_W-1:0]    pc_next_q;
   logic               valid_q;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         instr_q   <= NOP_INSTR;
         pc_next_q <= '0;
         valid_q   <= 1'b0;
      end else if (hold) begin
         instr_q   <= instr_q;
         pc_next_q <= pc_next_q;
         valid_q   <= valid_q;
      end else if (load) begin
         instr_q   <= instr_in;
         pc_next_q <= pc_next_in;
         valid_q   <= 1'b1;
      end else begin
         // Nothing delivered this cycle: downstream sees a bubble.
         instr_q   <= NOP_INSTR;
         pc_next_q <= '0;
         valid_q   <= 1'b0;
      end
   end

   assign instr   = instr_q;
   assign pc_next = pc_next_q;
   assign valid   = valid_q;

endmodule

// File: rtl/fetch_stage_ctrl.sv
// Instruction-fetch controller: PC register, variable-latency imem handshake,
// redirect latch and HALT freeze, feeding the IF/ID register.
module fetch_stage_ctrl
   import fetch_stage_ctrl_pkg::*;
#(
   parameter int unsigned        PC_W      = 16,
   parameter int unsigned        INSTR_W   = 16,
   parameter logic [PC_W-1:0]    RESET_PC  = '0,
   parameter logic [INSTR_W-1:0] NOP_INSTR = DEFAULT_NOP
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               PC_stall,
   input  logic               IF_ID_stall,
   input  logic               IF_flush,
   input  logic               update_PC,
   input  logic [PC_W-1:0]    branch_target,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               imem_ready,
   output logic [PC_W-1:0]    imem_addr,
   output logic               imem_en,
   output logic               fetch_stall,
   output logic [PC_W-1:0]    PC_curr,
   output logic [PC_W-1:0]    IF_ID_PC_next,
   output logic [INSTR_W-1:0] IF_ID_instr,
   output logic               IF_ID_valid,
   output logic               halted
);

   fetch_state_e    state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [PC_W-1:0] tgt_q, tgt_d;
   logic            pend_q, pend_d;
   logic [PC_W-1:0] pc_inc;
   logic            halt_hit;
   logic            ifid_load, ifid_hold, ifid_flush;

   assign pc_inc   = pc_q + PC_W'(INSTR_BYTES);
   assign halt_hit = IF_ID_valid && !IF_flush &&
                     (IF_ID_instr[INSTR_W-1 -: 4] == HLT_OPCODE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StFetch;
         pc_q    <= RESET_PC;
         tgt_q   <= '0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         tgt_q   <= tgt_d;
         pend_q  <= pend_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      tgt_d       = tgt_q;
      pend_d      = pend_q;
      imem_en     = 1'b0;
      fetch_stall = 1'b0;
      ifid_load   = 1'b0;
      ifid_hold   = IF_ID_stall;
      ifid_flush  = IF_flush;

      unique case (state_q)
         StFetch: begin
            imem_en = 1'b1;
            if (halt_hit) begin
               // HLT stays in IF/ID; the fetch in flight is dropped.
               state_d   = StHalt;
               ifid_hold = 1'b1;
            end else if (imem_ready) begin
               ifid_load = 1'b1;
               if (update_PC) begin
                  pc_d = branch_target;
               end else if (!PC_stall) begin
                  pc_d = pc_inc;
               end
            end else begin
               state_d = StWait;
               if (update_PC) begin
                  pc_d = branch_target;
               end
            end
         end

         StWait: begin
            imem_en     = 1'b1;
            fetch_stall = 1'b1;
            if (halt_hit) begin
               state_d   = StHalt;
               ifid_hold = 1'b1;
            end else if (imem_ready) begin
               state_d = StFetch;
               pend_d  = 1'b0;
               if (pend_q || update_PC) begin
                  // Completed access belongs to the squashed path: discard it.
                  pc_d = update_PC ? branch_target : tgt_q;
               end else begin
                  ifid_load = 1'b1;
                  if (!PC_stall) begin
                     pc_d = pc_inc;
                  end
               end
            end else if (update_PC) begin
               pend_d = 1'b1;
               tgt_d  = branch_target;
            end
         end

         StHalt: begin
            ifid_hold  = 1'b1;
            ifid_flush = 1'b0;
         end

         default: begin
            state_d = StFetch;
         end
      endcase
   end

   fetch_stage_ctrl_if_id_reg #(
      .PC_W      (PC_W),
      .INSTR_W   (INSTR_W),
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id_reg (
      .clk        (clk),
      .rst        (rst),
      .flush      (ifid_flush),
      .hold       (ifid_hold),
      .load       (ifid_load),
      .instr_in   (imem_rdata),
      .pc_next_in (pc_inc),
      .instr      (IF_ID_instr),
      .pc_next    (IF_ID_PC_next),
      .valid      (IF_ID_valid)
   );

   assign imem_addr = pc_q;
   assign PC_curr   = pc_q;
   assign halted    = (state_q == StHalt);

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Directed bench for fetch_stage_ctrl: expected state pushed to a scoreboard
// queue per step, popped and compared 1 ns after each rising edge.
module tb_fetch_stage_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        PC_stall = 1'b0;
   logic        IF_ID_stall = 1'b0;
   logic        IF_flush = 1'b0;
   logic        update_PC = 1'b0;
   logic [15:0] branch_target = 16'h0000;
   logic [15:0] imem_rdata;
   logic        imem_ready = 1'b1;
   logic [15:0] imem_addr;
   logic        imem_en;
   logic        fetch_stall;
   logic [15:0] PC_curr;
   logic [15:0] IF_ID_PC_next;
   logic [15:0] IF_ID_instr;
   logic        IF_ID_valid;
   logic        halted;

   logic [15:0] hlt_addr = 16'hFFFF;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      string       tag;
      logic [15:0] pc;
      logic [15:0] instr;
      logic [15:0] pcn;
      logic        valid;
      logic        fstall;
      logic        halted;
      logic        en;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   // Instruction memory image: a non-HLT word per address, one optional HLT.
   assign imem_rdata = (imem_addr == hlt_addr) ? 16'hF000 : {4'h1, imem_addr[11:0]};

   fetch_stage_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .PC_stall      (PC_stall),
      .IF_ID_stall   (IF_ID_stall),
      .IF_flush      (IF_flush),
      .update_PC     (update_PC),
      .branch_target (branch_target),
      .imem_rdata    (imem_rdata),
      .imem_ready    (imem_ready),
      .imem_addr     (imem_addr),
      .imem_en       (imem_en),
      .fetch_stall   (fetch_stall),
      .PC_curr       (PC_curr),
      .IF_ID_PC_next (IF_ID_PC_next),
      .IF_ID_instr   (IF_ID_instr),
      .IF_ID_valid   (IF_ID_valid),
      .halted        (halted)
   );

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return (a == hlt_addr) ? 16'hF000 : {4'h1, a[11:0]};
   endfunction

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic push(input string tag, input logic [15:0] pc, input logic [15:0] instr,
                       input logic [15:0] pcn, input logic valid, input logic fstall,
                       input logic hlt, input logic en);
      exp_t e;
      e.tag = tag; e.pc = pc; e.instr = instr; e.pcn = pcn;
      e.valid = valid; e.fstall = fstall; e.halted = hlt; e.en = en;
      sb.push_back(e);
   endtask

   // IF/ID holds the word fetched from address a.
   task automatic exp_run(input string tag, input logic [15:0] pc, input logic [15:0] a);
      push(tag, pc, mem_word(a), a + 16'd2, 1'b1, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic exp_bub(input string tag, input logic [15:0] pc, input logic fstall);
      push(tag, pc, 16'h0000, 16'h0000, 1'b0, fstall, 1'b0, 1'b1);
   endtask

   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      while (sb.size() != 0) begin
         e = sb.pop_front();
         chk({e.tag, ".pc"},     PC_curr,              e.pc);
         chk({e.tag, ".addr"},   imem_addr,            e.pc);
         chk({e.tag, ".instr"},  IF_ID_instr,          e.instr);
         chk({e.tag, ".pcn"},    IF_ID_PC_next,        e.pcn);
         chk({e.tag, ".valid"},  16'(IF_ID_valid),     16'(e.valid));
         chk({e.tag, ".fstall"}, 16'(fetch_stall),     16'(e.fstall));
         chk({e.tag, ".halted"}, 16'(halted),          16'(e.halted));
         chk({e.tag, ".en"},     16'(imem_en),         16'(e.en));
      end
   endtask

   initial begin
      // Reset
      exp_bub("reset", 16'h0000, 1'b0); tick();
      rst = 1'b0;

      // 1: free-running fetch
      exp_run("seq0", 16'h0002, 16'h0000); tick();
      exp_run("seq1", 16'h0004, 16'h0002); tick();
      exp_run("seq2", 16'h0006, 16'h0004); tick();
      exp_run("seq3", 16'h0008, 16'h0006); tick();

      // 2: PC and IF/ID stalled two cycles at PC=8
      PC_stall = 1'b1; IF_ID_stall = 1'b1;
      exp_run("stall0", 16'h0008, 16'h0006); tick();
      exp_run("stall1", 16'h0008, 16'h0006); tick();
      PC_stall = 1'b0; IF_ID_stall = 1'b0;
      exp_run("rel0", 16'h000A, 16'h0008); tick();
      exp_run("rel1", 16'h000C, 16'h000A); tick();

      // 3: redirect plus flush at PC=12, with IF_ID_stall to show flush wins
      update_PC = 1'b1; branch_target = 16'h0040; IF_flush = 1'b1; IF_ID_stall = 1'b1;
      PC_stall = 1'b1;
      exp_bub("redir", 16'h0040, 1'b0); tick();
      update_PC = 1'b0; IF_flush = 1'b0; IF_ID_stall = 1'b0; PC_stall = 1'b0;
      exp_run("tgt", 16'h0042, 16'h0040); tick();

      // 4: memory wait of three cycles at PC=4
      update_PC = 1'b1; branch_target = 16'h0004; IF_flush = 1'b1;
      exp_bub("to4", 16'h0004, 1'b0); tick();
      update_PC = 1'b0; IF_flush = 1'b0; imem_ready = 1'b0;
      exp_bub("wait0", 16'h0004, 1'b1); tick();
      exp_bub("wait1", 16'h0004, 1'b1); tick();
      exp_bub("wait2", 16'h0004, 1'b1); tick();
      imem_ready = 1'b1;
      exp_run("waitdone", 16'h0006, 16'h0004); tick();

      // 5: redirect arrives while waiting
      imem_ready = 1'b0;
      exp_bub("w5a", 16'h0006, 1'b1); tick();
      update_PC = 1'b1; branch_target = 16'h0080;
      exp_bub("w5b", 16'h0006, 1'b1); tick();
      update_PC = 1'b0; imem_ready = 1'b1;
      exp_bub("discard", 16'h0080, 1'b0); tick();
      exp_run("f80", 16'h0082, 16'h0080); tick();

      // 6: HLT at 0x84 reaches IF/ID, fetch freezes
      hlt_addr = 16'h0084;
      exp_run("preh", 16'h0084, 16'h0082); tick();
      exp_run("hltin", 16'h0086, 16'h0084); tick();
      push("halt", 16'h0086, 16'hF000, 16'h0086, 1'b1, 1'b0, 1'b1, 1'b0); tick();
      update_PC = 1'b1; branch_target = 16'h0100; IF_flush = 1'b1;
      for (int i = 0; i < 10; i++) begin
         push("frozen", 16'h0086, 16'hF000, 16'h0086, 1'b1, 1'b0, 1'b1, 1'b0); tick();
      end

      // Reset out of HALT, overriding the other inputs
      rst = 1'b1;
      exp_bub("rsthlt", 16'h0000, 1'b0); tick();
      rst = 1'b0; update_PC = 1'b0; IF_flush = 1'b0;
      exp_run("post", 16'h0002, 16'h0000); tick();

      // PC wrap from 0xFFFE to 0
      update_PC = 1'b1; branch_target = 16'hFFFE; IF_flush = 1'b1;
      exp_bub("tofffe", 16'hFFFE, 1'b0); tick();
      update_PC = 1'b0; IF_flush = 1'b0;
      exp_run("wrap", 16'h0000, 16'hFFFE); tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
